// File: rtl/thermal_throttle_ctrl.sv
// thermal_throttle_ctrl
//   Samples each core's temperature round-robin, smooths it with a 4-tap
//   moving average and classifies the core into a hysteretic thermal zone.
//   Drives a per-core PWM duty and zone, a zone-change pulse and a
//   cluster-wide critical flag.
//
//   Ports:
//     CLK       system clock
//     RST       synchronous reset, active-high
//     temp_in   core i temperature in [7i+6:7i], unsigned degrees C
//     duty_out  core i PWM duty in [8i+7:8i]
//     zone_out  core i zone in [2i+1:2i]
//     zone_chg  one-cycle pulse when core i's zone changes
//     crit_any  high while any core is in CRIT
//     sel_out   core index sampled on the current tick (debug)
//
//   Optional build macro: THERM_STICKY_CRIT_EN makes CRIT absorbing until RST.
//
//   Zone FSM (one instance per core, advanced only on that core's update):
//     state | meaning
//     COOL  | avg below T_WARM, duty 64
//     WARM  | avg reached T_WARM, duty 128
//     HOT   | avg reached T_HOT, duty 192
//     CRIT  | avg reached T_CRIT, duty 255
//   Up-moves jump straight to the highest zone reached; down-moves take one
//   step per update and only once avg is more than HYST below the threshold.

module thermal_throttle_ctrl #(
    parameter int NUM_CORES  = 3,
    parameter int SAMPLE_DIV = 16,
    parameter int T_WARM     = 50,
    parameter int T_HOT      = 70,
    parameter int T_CRIT     = 76,
    parameter int HYST       = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_CORES*7-1:0] temp_in,
    output logic [NUM_CORES*8-1:0] duty_out,
    output logic [NUM_CORES*2-1:0] zone_out,
    output logic [NUM_CORES-1:0]   zone_chg,
    output logic                   crit_any,
    output logic [1:0]             sel_out
);

    localparam int               CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [1:0]       SEL_LAST = 2'(NUM_CORES - 1);
    localparam logic [7:0]       THR_WARM = 8'(T_WARM);
    localparam logic [7:0]       THR_HOT  = 8'(T_HOT);
    localparam logic [7:0]       THR_CRIT = 8'(T_CRIT);
    localparam logic [7:0]       HYST_L   = 8'(HYST);

    typedef enum logic [1:0] {
        ZONE_COOL = 2'd0,
        ZONE_WARM = 2'd1,
        ZONE_HOT  = 2'd2,
        ZONE_CRIT = 2'd3
    } zone_e;

    function automatic logic [7:0] zone_thr(input zone_e z);
        case (z)
            ZONE_WARM: zone_thr = THR_WARM;
            ZONE_HOT:  zone_thr = THR_HOT;
            ZONE_CRIT: zone_thr = THR_CRIT;
            default:   zone_thr = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] zone_duty(input zone_e z);
        case (z)
            ZONE_WARM: zone_duty = 8'd128;
            ZONE_HOT:  zone_duty = 8'd192;
            ZONE_CRIT: zone_duty = 8'd255;
            default:   zone_duty = 8'd64;
        endcase
    endfunction

    function automatic zone_e zone_next(input zone_e cur, input logic [6:0] avg);
        logic [7:0] a;
        zone_e      up;
        a = {1'b0, avg};
        if (a >= THR_CRIT)      up = ZONE_CRIT;
        else if (a >= THR_HOT)  up = ZONE_HOT;
        else if (a >= THR_WARM) up = ZONE_WARM;
        else                    up = ZONE_COOL;
        zone_next = cur;
        // Down test written as avg + HYST < thr so nothing can go negative.
        if (up > cur)
            zone_next = up;
        else if (cur != ZONE_COOL && (a + HYST_L) < zone_thr(cur))
            zone_next = zone_e'(cur - 2'd1);
`ifdef THERM_STICKY_CRIT_EN
        if (cur == ZONE_CRIT)
            zone_next = ZONE_CRIT;
`endif
    endfunction

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [6:0]           hist_q [NUM_CORES][4];
    logic [6:0]           hist_d [NUM_CORES][4];
    logic [NUM_CORES-1:0] primed_q, primed_d;
    logic                 upd_v_q, upd_v_d;
    logic [1:0]           upd_sel_q, upd_sel_d;
    zone_e                zone_q [NUM_CORES];
    zone_e                zone_d [NUM_CORES];
    logic [7:0]           duty_q [NUM_CORES];
    logic [7:0]           duty_d [NUM_CORES];
    logic [NUM_CORES-1:0] chg_q, chg_d;
    logic                 crit_q, crit_d;

    logic                 tick;
    logic [8:0]           sum;
    logic [6:0]           avg;

    assign tick = (cnt_q == CNT_LAST);

    // Stage 1: divider, round-robin select and history capture.
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        sel_d     = sel_q;
        hist_d    = hist_q;
        primed_d  = primed_q;
        upd_v_d   = 1'b0;
        upd_sel_d = upd_sel_q;
        if (tick) begin
            upd_v_d   = 1'b1;
            upd_sel_d = sel_q;
            sel_d     = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (sel_q == 2'(i)) begin
                    if (primed_q[i]) begin
                        hist_d[i][3] = hist_q[i][2];
                        hist_d[i][2] = hist_q[i][1];
                        hist_d[i][1] = hist_q[i][0];
                        hist_d[i][0] = temp_in[7*i +: 7];
                    end else begin
                        // First sample after reset fills the window so the
                        // average starts at the real temperature, not at 0.
                        for (int k = 0; k < 4; k++)
                            hist_d[i][k] = temp_in[7*i +: 7];
                    end
                    primed_d[i] = 1'b1;
                end
            end
        end
    end

    // Stage 2: average the just-written history and advance that core's zone.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (upd_sel_q == 2'(i))
                sum = {2'b00, hist_q[i][0]} + {2'b00, hist_q[i][1]}
                    + {2'b00, hist_q[i][2]} + {2'b00, hist_q[i][3]};
        end
        avg = 7'(sum >> 2);

        zone_d = zone_q;
        duty_d = duty_q;
        chg_d  = '0;
        if (upd_v_q) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (upd_sel_q == 2'(i)) begin
                    zone_d[i] = zone_next(zone_q[i], avg);
                    duty_d[i] = zone_duty(zone_d[i]);
                    chg_d[i]  = (zone_d[i] != zone_q[i]);
                end
            end
        end

        crit_d = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (zone_d[i] == ZONE_CRIT)
                crit_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            sel_q     <= '0;
            primed_q  <= '0;
            upd_v_q   <= 1'b0;
            upd_sel_q <= '0;
            chg_q     <= '0;
            crit_q    <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                zone_q[i] <= ZONE_COOL;
                duty_q[i] <= 8'd64;
                for (int k = 0; k < 4; k++)
                    hist_q[i][k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            primed_q  <= primed_d;
            upd_v_q   <= upd_v_d;
            upd_sel_q <= upd_sel_d;
            chg_q     <= chg_d;
            crit_q    <= crit_d;
            hist_q    <= hist_d;
            zone_q    <= zone_d;
            duty_q    <= duty_d;
        end
    end

    always_comb begin
        zone_out = '0;
        duty_out = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            zone_out[2*i +: 2] = zone_q[i];
            duty_out[8*i +: 8] = duty_q[i];
        end
    end

    assign zone_chg = chg_q;
    assign crit_any = crit_q;
    assign sel_out  = sel_q;

endmodule

// File: tb/tb_thermal_throttle_ctrl.sv
// Bench for thermal_throttle_ctrl: a sample-level model (history queues,
// integer averages, threshold table) checked against the DUT every cycle,
// plus directed scenarios with hand-computed zone/duty/pulse values.
module tb_thermal_throttle_ctrl;

    localparam int NUM_CORES  = 3;
    localparam int SAMPLE_DIV = 16;
    localparam int T_WARM     = 50;
    localparam int T_HOT      = 70;
    localparam int T_CRIT     = 76;
    localparam int HYST       = 3;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [NUM_CORES*7-1:0] temp_in;
    logic [NUM_CORES*8-1:0] duty_out;
    logic [NUM_CORES*2-1:0] zone_out;
    logic [NUM_CORES-1:0]   zone_chg;
    logic                   crit_any;
    logic [1:0]             sel_out;

    thermal_throttle_ctrl #(
        .NUM_CORES(NUM_CORES), .SAMPLE_DIV(SAMPLE_DIV), .T_WARM(T_WARM),
        .T_HOT(T_HOT), .T_CRIT(T_CRIT), .HYST(HYST)
    ) dut (
        .CLK(CLK), .RST(RST), .temp_in(temp_in), .duty_out(duty_out),
        .zone_out(zone_out), .zone_chg(zone_chg), .crit_any(crit_any),
        .sel_out(sel_out)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- model ----------------
    int                   m_hist [NUM_CORES][$];
    int                   m_zone [NUM_CORES];
    int                   m_cnt, m_sel, m_pend_core, m_upd_core;
    bit                   m_pend, m_upd, m_crit;
    logic [NUM_CORES-1:0] m_chg;
    int                   ms, mnz, mv;

`ifdef THERM_STICKY_CRIT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    function automatic int model_zone(input int cur, input int avg);
        int thr[4];
        int up;
        thr[0] = 0; thr[1] = T_WARM; thr[2] = T_HOT; thr[3] = T_CRIT;
        up = 0;
        for (int z = 1; z < 4; z++)
            if (avg >= thr[z]) up = z;
        if (STICKY && cur == 3) return 3;
        if (up > cur) return up;
        if (cur > 0 && avg < thr[cur] - HYST) return cur - 1;
        return cur;
    endfunction

    function automatic int duty_of(input int z);
        case (z)
            0: return 64;
            1: return 128;
            2: return 192;
            default: return 255;
        endcase
    endfunction

    task automatic model_step();
        if (RST) begin
            m_cnt = 0; m_sel = 0; m_pend = 0; m_upd = 0; m_chg = '0; m_crit = 0;
            for (int c = 0; c < NUM_CORES; c++) begin
                m_hist[c].delete();
                m_zone[c] = 0;
            end
        end else begin
            m_upd = 0;
            m_chg = '0;
            if (m_pend) begin
                ms = 0;
                for (int k = 0; k < m_hist[m_pend_core].size(); k++)
                    ms += m_hist[m_pend_core][k];
                mnz = model_zone(m_zone[m_pend_core], ms / 4);
                if (mnz != m_zone[m_pend_core]) m_chg[m_pend_core] = 1'b1;
                m_zone[m_pend_core] = mnz;
                m_upd      = 1;
                m_upd_core = m_pend_core;
                m_pend     = 0;
            end
            if (m_cnt == SAMPLE_DIV - 1) begin
                mv = int'(temp_in[7*m_sel +: 7]);
                if (m_hist[m_sel].size() == 0) begin
                    repeat (4) m_hist[m_sel].push_front(mv);
                end else begin
                    m_hist[m_sel].push_front(mv);
                    void'(m_hist[m_sel].pop_back());
                end
                m_pend      = 1;
                m_pend_core = m_sel;
                m_sel       = (m_sel + 1) % NUM_CORES;
            end
            m_cnt  = (m_cnt + 1) % SAMPLE_DIV;
            m_crit = 0;
            for (int c = 0; c < NUM_CORES; c++)
                if (m_zone[c] == 3) m_crit = 1;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    task automatic compare_cycle();
        logic [NUM_CORES*8-1:0] ed;
        logic [NUM_CORES*2-1:0] ez;
        for (int c = 0; c < NUM_CORES; c++) begin
            ez[2*c +: 2] = 2'(m_zone[c]);
            ed[8*c +: 8] = 8'(duty_of(m_zone[c]));
        end
        n_total++;
        if (zone_out === ez && duty_out === ed && zone_chg === m_chg &&
            crit_any === m_crit && sel_out === 2'(m_sel))
            n_pass++;
        else
            $display("FAIL model_cmp t=%0t zone got=%h exp=%h duty got=%h exp=%h chg got=%b exp=%b crit got=%b exp=%b sel got=%0d exp=%0d",
                     $time, zone_out, ez, duty_out, ed, zone_chg, m_chg,
                     crit_any, m_crit, sel_out, m_sel);
    endtask

    initial forever begin
        @(negedge CLK);
        compare_cycle();
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int zone_of(input int c);
        return int'(zone_out[2*c +: 2]);
    endfunction

    function automatic int duty_dut(input int c);
        return int'(duty_out[8*c +: 8]);
    endfunction

    task automatic check_core(input string name, input int c, input int z,
                              input int d, input int chg);
        check({name, "_zone"}, zone_of(c), z);
        check({name, "_duty"}, duty_dut(c), d);
        check({name, "_chg"}, int'(zone_chg[c]), chg);
    endtask

    task automatic set_temp(input int c, input int v);
        temp_in[7*c +: 7] = 7'(v);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_update(input int c);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge CLK);
            n++;
            if (m_upd && m_upd_core == c) seen = 1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL wait_update core %0d: no update within %0d cycles", c, n);
        end
    endtask

    // CRIT-cooldown expectations for core1 (avg 75, 60, 45, 30, 30).
    int s4_zone[5];
    int s4_chg[5];

    initial begin
        RST     = 1'b1;
        temp_in = '0;
        repeat (2) @(negedge CLK);

        // S1: reset state, idle temperature, select rotation
        for (int c = 0; c < NUM_CORES; c++) set_temp(c, 39);
        check("rst_zone", int'(zone_out), 0);
        check("rst_duty", int'(duty_out), 'h404040);
        check("rst_chg", int'(zone_chg), 0);
        check("rst_crit", int'(crit_any), 0);
        check("rst_sel", int'(sel_out), 0);
        RST = 1'b0;
        wait_update(0);
        check_core("s1_c0", 0, 0, 64, 0);
        check("s1_sel_a", int'(sel_out), 1);
        wait_update(1);
        check_core("s1_c1", 1, 0, 64, 0);
        check("s1_sel_b", int'(sel_out), 2);
        wait_update(2);
        check_core("s1_c2", 2, 0, 64, 0);
        check("s1_sel_wrap", int'(sel_out), 0);

        // S2: core2 primed at 40, then 80s -> avg 50, 60, 70, 80
        set_temp(2, 40);
        do_reset(2);
        wait_update(2);
        check_core("s2_prime", 2, 0, 64, 0);
        set_temp(2, 80);
        wait_update(2);
        check_core("s2_avg50", 2, 1, 128, 1);
        wait_update(2);
        check_core("s2_avg60", 2, 1, 128, 0);
        wait_update(2);
        check_core("s2_avg70", 2, 2, 192, 1);
        check("s2_crit_lo", int'(crit_any), 0);
        wait_update(2);
        check_core("s2_avg80", 2, 3, 255, 1);
        check("s2_crit_hi", int'(crit_any), 1);

        // S3: CRIT hysteresis; a glitch between ticks must be ignored
        set_temp(2, 73);
        wait_update(2);
        check_core("s3_avg78", 2, 3, 255, 0);
        set_temp(2, 68);
        wait_update(2);
        check_core("s3_avg75", 2, 3, 255, 0);
        set_temp(2, 127);
        repeat (3) @(negedge CLK);
        set_temp(2, 68);
        wait_update(2);
        if (STICKY) begin
            check_core("s3_avg72_sticky", 2, 3, 255, 0);
            check("s3_crit_sticky", int'(crit_any), 1);
        end else begin
            check_core("s3_avg72", 2, 2, 192, 1);
            check("s3_crit", int'(crit_any), 0);
        end

        // S4: core1 jumps to CRIT, then cools one zone per update
        if (STICKY) begin
            s4_zone = '{3, 3, 3, 3, 3};
            s4_chg  = '{0, 0, 0, 0, 0};
        end else begin
            s4_zone = '{3, 2, 1, 0, 0};
            s4_chg  = '{0, 1, 1, 1, 0};
        end
        set_temp(0, 39);
        set_temp(1, 90);
        set_temp(2, 39);
        do_reset(2);
        wait_update(1);
        check_core("s4_hot_prime", 1, 3, 255, 1);
        set_temp(1, 30);
        for (int u = 0; u < 5; u++) begin
            wait_update(1);
            check_core($sformatf("s4_cool%0d", u), 1, s4_zone[u],
                       duty_of(s4_zone[u]), s4_chg[u]);
        end

        // S5: core0 COOL, then reset + prime at 80 -> direct COOL->CRIT
        set_temp(0, 30);
        do_reset(2);
        wait_update(0);
        check_core("s5_cool", 0, 0, 64, 0);
        set_temp(0, 80);
        do_reset(1);
        wait_update(0);
        check_core("s5_jump", 0, 3, 255, 1);
        check("s5_crit", int'(crit_any), 1);
        @(negedge CLK);
        check_core("s5_after", 0, 3, 255, 0);

        // S6: RST while core2 is CRIT, landing on a tick cycle
        set_temp(0, 39);
        set_temp(2, 90);
        do_reset(2);
        wait_update(2);
        check_core("s6_crit", 2, 3, 255, 1);
        repeat (SAMPLE_DIV - 2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_core("s6_rst", 2, 0, 64, 0);
        check("s6_rst_crit", int'(crit_any), 0);
        check("s6_rst_sel", int'(sel_out), 0);
        set_temp(2, 45);
        wait_update(2);
        check_core("s6_reprime", 2, 0, 64, 0);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
